// File: rtl/bru_pkg.sv
// ============================================================================
// Module   : bru_pkg
// Brief    : Shared types and constants for the branch resolve unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bru_pkg;

  // Width of the PC fields held in each in-flight entry.
  localparam int BRU_XLEN   = 32;

  // Fall-through increment applied to a branch PC when it was not taken.
  localparam int BRU_PC_INC = 4;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bru_state_t;

  typedef struct packed {
    logic [BRU_XLEN-1:0] pc;
    logic [BRU_XLEN-1:0] target;
    logic                pred;
  } bru_entry_t;

endpackage

`default_nettype wire

// File: rtl/bru_fifo.sv
// ============================================================================
// Module   : bru_fifo
// Brief    : In-order storage for in-flight branches. Pointers carry one
//            extra wrap bit so full and empty are distinguishable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bru_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  bru_entry_t               wdata_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output bru_entry_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  bru_entry_t    mem_q [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A clear squashes everything, including a push presented in the same cycle.
  assign w_do_push = push_i && !full_o && !clear_i;
  assign w_do_pop  = pop_i && !empty_o && !clear_i;

  // Pointer update; clear empties the queue by catching the read pointer up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Tracks conditional branches from ID to EX, trains the predictor
//            and issues a one-cycle flush with the corrected fetch PC when a
//            prediction turns out wrong.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_branch_valid,
  input  logic [XLEN-1:0]        id_pc,
  input  logic [XLEN-1:0]        id_target,
  input  logic                   id_prediction,
  output logic                   alloc_ready,
  input  logic                   ex_valid,
  input  logic                   ex_taken,
  output logic                   actual_outcome,
  output logic                   branch_EX_done,
  output logic                   mispredict,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] inflight_count,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  bru_state_t      state_q;
  logic            actual_outcome_q;
  logic            branch_ex_done_q;
  logic            mispredict_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            err_overflow_q;
  logic            err_underflow_q;

  bru_entry_t      w_wentry;
  bru_entry_t      w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_resolve;
  logic            w_mispred;
  logic [XLEN-1:0] w_redirect;

  assign w_wentry.pc     = BRU_XLEN'(id_pc);
  assign w_wentry.target = BRU_XLEN'(id_target);
  assign w_wentry.pred   = id_prediction;

  // Allocation looks only at registered state, so a same-cycle pop never
  // opens a slot for the branch in ID.
  assign alloc_ready = (state_q == NORMAL) && !w_full;

  assign w_resolve  = ex_valid && !w_empty;
  assign w_mispred  = w_resolve && (w_head.pred != ex_taken);
  // A push alongside a mispredict belongs to the wrong path and is dropped.
  assign w_push     = id_branch_valid && alloc_ready && !w_mispred;
  assign w_redirect = ex_taken ? XLEN'(w_head.target)
                               : XLEN'(w_head.pc) + XLEN'(BRU_PC_INC);

  bru_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .wdata_i (w_wentry),
    .pop_i   (w_resolve && !w_mispred),
    .clear_i (w_mispred),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (inflight_count)
  );

  // Recovery FSM plus the registered predictor-training and flush outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= NORMAL;
      actual_outcome_q <= 1'b0;
      branch_ex_done_q <= 1'b0;
      mispredict_q     <= 1'b0;
      redirect_pc_q    <= '0;
      err_overflow_q   <= 1'b0;
      err_underflow_q  <= 1'b0;
    end else begin
      branch_ex_done_q <= w_resolve;
      mispredict_q     <= w_mispred;
      if (w_resolve) actual_outcome_q <= ex_taken;
      if (w_mispred) redirect_pc_q    <= w_redirect;
      if (id_branch_valid && w_full) err_overflow_q  <= 1'b1;
      if (ex_valid && w_empty)       err_underflow_q <= 1'b1;

      // RECOVER lasts one cycle so the front end can refetch from redirect_pc.
      if (state_q == RECOVER) begin
        state_q <= NORMAL;
      end else if (w_mispred) begin
        state_q <= RECOVER;
      end
    end
  end

  assign actual_outcome = actual_outcome_q;
  assign branch_EX_done = branch_ex_done_q;
  assign mispredict     = mispredict_q;
  assign redirect_pc    = redirect_pc_q;
  assign err_overflow   = err_overflow_q;
  assign err_underflow  = err_underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Scoreboard bench for branch_resolve_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic                   clk;
  logic                   rst;
  logic                   id_branch_valid;
  logic [XLEN-1:0]        id_pc;
  logic [XLEN-1:0]        id_target;
  logic                   id_prediction;
  logic                   alloc_ready;
  logic                   ex_valid;
  logic                   ex_taken;
  logic                   actual_outcome;
  logic                   branch_EX_done;
  logic                   mispredict;
  logic [XLEN-1:0]        redirect_pc;
  logic [$clog2(DEPTH):0] inflight_count;
  logic                   err_overflow;
  logic                   err_underflow;

  typedef struct {
    logic            outcome;
    logic            mis;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_resolve_unit #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_branch_valid (id_branch_valid),
    .id_pc           (id_pc),
    .id_target       (id_target),
    .id_prediction   (id_prediction),
    .alloc_ready     (alloc_ready),
    .ex_valid        (ex_valid),
    .ex_taken        (ex_taken),
    .actual_outcome  (actual_outcome),
    .branch_EX_done  (branch_EX_done),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .inflight_count  (inflight_count),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic pred);
    id_branch_valid = 1'b1;
    id_pc           = pc;
    id_target       = tgt;
    id_prediction   = pred;
    cyc();
    id_branch_valid = 1'b0;
  endtask

  task automatic expect_pulse(input logic outcome, input logic mis, input logic [XLEN-1:0] pc);
    exp_t e;
    e.outcome = outcome;
    e.mis     = mis;
    e.pc      = pc;
    sb.push_back(e);
  endtask

  task automatic resolve(input logic taken, input logic outcome, input logic mis,
                         input logic [XLEN-1:0] pc);
    ex_valid = 1'b1;
    ex_taken = taken;
    expect_pulse(outcome, mis, pc);
    cyc();
    ex_valid = 1'b0;
  endtask

  // Monitor: every training pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && branch_EX_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("actual_outcome", 32'(actual_outcome), 32'(e.outcome));
        chk("mispredict", 32'(mispredict), 32'(e.mis));
        if (e.mis) chk("redirect_pc", redirect_pc, e.pc);
      end
    end else if (!rst && mispredict) begin
      n_checks++;
      n_fail++;
      $display("FAIL mispredict_without_done actual=1 required=0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    id_branch_valid = 1'b0;
    id_pc           = '0;
    id_target       = '0;
    id_prediction   = 1'b0;
    ex_valid        = 1'b0;
    ex_taken        = 1'b0;
    cyc();
    cyc();
    chk("rst_count", 32'(inflight_count), 32'd0);
    chk("rst_done", 32'(branch_EX_done), 32'd0);
    chk("rst_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    rst = 1'b0;
    cyc();
    chk("alloc_after_rst", 32'(alloc_ready), 32'd1);

    // Fill to capacity, then overflow.
    push(32'h10, 32'h110, 1'b1);
    push(32'h20, 32'h120, 1'b1);
    push(32'h30, 32'h130, 1'b1);
    chk("count3", 32'(inflight_count), 32'd3);
    chk("alloc3", 32'(alloc_ready), 32'd1);
    push(32'h40, 32'h80, 1'b1);
    chk("count4", 32'(inflight_count), 32'd4);
    chk("alloc_full", 32'(alloc_ready), 32'd0);
    chk("ovf_clear", 32'(err_overflow), 32'd0);
    push(32'h50, 32'h150, 1'b1);
    chk("count_ovf", 32'(inflight_count), 32'd4);
    chk("err_overflow", 32'(err_overflow), 32'd1);

    // Correct taken predictions, back-to-back.
    resolve(1'b1, 1'b1, 1'b0, '0);
    chk("count_pop1", 32'(inflight_count), 32'd3);
    resolve(1'b1, 1'b1, 1'b0, '0);
    resolve(1'b1, 1'b1, 1'b0, '0);
    chk("count_pop3", 32'(inflight_count), 32'd1);
    chk("done_b2b", 32'(branch_EX_done), 32'd1);

    // Predicted taken, actually not taken: fall-through redirect.
    resolve(1'b0, 1'b0, 1'b1, 32'h44);
    chk("count_mis", 32'(inflight_count), 32'd0);
    chk("alloc_recover", 32'(alloc_ready), 32'd0);
    chk("mis_pulse", 32'(mispredict), 32'd1);
    id_branch_valid = 1'b1;
    id_pc           = 32'h99;
    id_target       = 32'h999;
    id_prediction   = 1'b1;
    cyc();
    id_branch_valid = 1'b0;
    chk("count_after_recover", 32'(inflight_count), 32'd0);
    chk("alloc_normal", 32'(alloc_ready), 32'd1);
    chk("mis_one_cycle", 32'(mispredict), 32'd0);

    // PC wrap on the fall-through path.
    push(32'hFFFF_FFFC, 32'h1234, 1'b1);
    resolve(1'b0, 1'b0, 1'b1, 32'h0);
    chk("redirect_wrap", redirect_pc, 32'h0);
    cyc();

    // Predicted not taken, actually taken, with a wrong-path push in the same cycle.
    push(32'h60, 32'h100, 1'b0);
    push(32'h70, 32'h200, 1'b1);
    chk("count2", 32'(inflight_count), 32'd2);
    ex_valid        = 1'b1;
    ex_taken        = 1'b1;
    id_branch_valid = 1'b1;
    id_pc           = 32'h90;
    id_target       = 32'h300;
    id_prediction   = 1'b1;
    expect_pulse(1'b1, 1'b1, 32'h100);
    cyc();
    ex_valid        = 1'b0;
    id_branch_valid = 1'b0;
    chk("count_squash", 32'(inflight_count), 32'd0);
    cyc();
    chk("count_squash_hold", 32'(inflight_count), 32'd0);

    // Correct not-taken prediction with a simultaneous push.
    push(32'hA0, 32'hB0, 1'b0);
    ex_valid        = 1'b1;
    ex_taken        = 1'b0;
    id_branch_valid = 1'b1;
    id_pc           = 32'hC0;
    id_target       = 32'hD0;
    id_prediction   = 1'b1;
    expect_pulse(1'b0, 1'b0, '0);
    cyc();
    ex_valid        = 1'b0;
    id_branch_valid = 1'b0;
    chk("count_push_pop", 32'(inflight_count), 32'd1);
    resolve(1'b1, 1'b1, 1'b0, '0);
    chk("count_empty", 32'(inflight_count), 32'd0);

    // Resolve with nothing in flight.
    chk("unf_clear", 32'(err_underflow), 32'd0);
    ex_valid = 1'b1;
    ex_taken = 1'b1;
    cyc();
    ex_valid = 1'b0;
    chk("unf_no_pulse", 32'(branch_EX_done), 32'd0);
    cyc();
    chk("err_underflow", 32'(err_underflow), 32'd1);

    // Asynchronous reset with two branches in flight.
    push(32'h200, 32'h300, 1'b1);
    push(32'h210, 32'h310, 1'b0);
    chk("count_pre_rst", 32'(inflight_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(inflight_count), 32'd0);
    chk("arst_errs", {30'd0, err_overflow, err_underflow}, 32'd0);
    chk("arst_outcome", 32'(actual_outcome), 32'd0);
    chk("arst_redirect", redirect_pc, 32'd0);
    cyc();
    rst      = 1'b0;
    ex_valid = 1'b1;
    ex_taken = 1'b1;
    cyc();
    ex_valid = 1'b0;
    cyc();
    cyc();
    chk("post_rst_count", 32'(inflight_count), 32'd0);
    chk("post_rst_underflow", 32'(err_underflow), 32'd1);
    chk("pending_pulses", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
